stdp_trace: RTL and testbench

Spike-timing trace engine that sits directly upstream of the STDP weight-update block. It keeps one decaying 8-bit eligibility trace for presynaptic spikes and one for postsynaptic spikes. On each spike it reads the opposite trace and emits a signed weight-change event (potentiation or depression) through a valid/ready handshake. The consumer applies that event to the synaptic weight that drives the LIF neuron's input current.

---
 rtl/stdp_trace.sv | 89 ++++++++
 tb/tb_stdp_trace.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/stdp_trace.sv
// Pre/post STDP eligibility traces with a one-slot signed weight-change event output; latency 1.
// Backpressure: a stalled event is held stable; a new event arriving at a full slot is dropped and flagged.
module stdp_trace #(
   parameter int DECAY_DIV   = 4,
   parameter int DECAY_SHIFT = 3,
   parameter int LTP_SHIFT   = 1,
   parameter int LTD_SHIFT   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pre_spike,
   input  logic       post_spike,
   output logic [7:0] pre_trace,
   output logic [7:0] post_trace,
   output logic       dw_valid,
   output logic       dw_sign,
   output logic [7:0] dw_mag,
   input  logic       dw_ready,
   output logic       dw_overflow
);

   localparam logic [7:0] DIV_LAST = 8'(DECAY_DIV - 1);

   logic [7:0] div_cnt;
   logic       tick;
   logic [7:0] ltp_mag;
   logic [7:0] ltd_mag;
   logic       ltp;
   logic       ltd;
   logic       new_ev;
   logic       xfer;

   // Small traces still step down by one so they always reach 0.
   function automatic logic [7:0] decay(input logic [7:0] t);
      logic [7:0] d;
      d = t >> DECAY_SHIFT;
      if (d != 8'd0)
         return t - d;
      else if (t != 8'd0)
         return t - 8'd1;
      else
         return t;
   endfunction

   always_comb begin
      tick    = (div_cnt == DIV_LAST);
      ltp_mag = pre_trace >> LTP_SHIFT;
      ltd_mag = post_trace >> LTD_SHIFT;
      ltp     = post_spike && !pre_spike && (ltp_mag != 8'd0);
      ltd     = pre_spike && !post_spike && (ltd_mag != 8'd0);
      new_ev  = ltp || ltd;
      xfer    = dw_valid && dw_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt     <= 8'd0;
         pre_trace   <= 8'd0;
         post_trace  <= 8'd0;
         dw_valid    <= 1'b0;
         dw_sign     <= 1'b0;
         dw_mag      <= 8'd0;
         dw_overflow <= 1'b0;
      end else begin
         div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;

         if (pre_spike)
            pre_trace <= 8'd255;
         else if (tick)
            pre_trace <= decay(pre_trace);

         if (post_spike)
            post_trace <= 8'd255;
         else if (tick)
            post_trace <= decay(post_trace);

         if (new_ev && (!dw_valid || xfer)) begin
            dw_valid <= 1'b1;
            dw_sign  <= ltp;
            dw_mag   <= ltp ? ltp_mag : ltd_mag;
         end else if (new_ev) begin
            dw_overflow <= 1'b1;
         end else if (xfer) begin
            dw_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stdp_trace.sv
// Randomized and directed bench for stdp_trace against a cycle-count based reference model.
module tb_stdp_trace;

   localparam int DIV = 4;
   localparam int DSH = 3;
   localparam int LTPS = 1;
   localparam int LTDS = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pre_spike = 1'b0;
   logic       post_spike = 1'b0;
   logic       dw_ready = 1'b0;
   logic [7:0] pre_trace;
   logic [7:0] post_trace;
   logic       dw_valid;
   logic       dw_sign;
   logic [7:0] dw_mag;
   logic       dw_overflow;

   int n_vec = 0;
   int n_err = 0;

   // reference state
   int m_pre, m_post, m_cyc, m_mag;
   bit m_vld, m_sign, m_ovf;

   stdp_trace #(.DECAY_DIV(DIV), .DECAY_SHIFT(DSH), .LTP_SHIFT(LTPS), .LTD_SHIFT(LTDS)) dut (
      .clk        (clk),
      .rst        (rst),
      .pre_spike  (pre_spike),
      .post_spike (post_spike),
      .pre_trace  (pre_trace),
      .post_trace (post_trace),
      .dw_valid   (dw_valid),
      .dw_sign    (dw_sign),
      .dw_mag     (dw_mag),
      .dw_ready   (dw_ready),
      .dw_overflow(dw_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int decay(input int t);
      int d;
      d = t / (1 << DSH);
      if (d > 0) return t - d;
      if (t > 0) return t - 1;
      return 0;
   endfunction

   task automatic model_edge();
      bit tick, ev, sg, xf;
      int mg;
      if (rst) begin
         m_pre = 0; m_post = 0; m_cyc = 0;
         m_vld = 0; m_sign = 0; m_mag = 0; m_ovf = 0;
         return;
      end
      tick = (m_cyc % DIV) == DIV - 1;
      m_cyc++;
      ev = 0; sg = 0; mg = 0;
      if (post_spike && !pre_spike && m_pre / (1 << LTPS) > 0) begin
         ev = 1; sg = 1; mg = m_pre / (1 << LTPS);
      end else if (pre_spike && !post_spike && m_post / (1 << LTDS) > 0) begin
         ev = 1; sg = 0; mg = m_post / (1 << LTDS);
      end
      xf = m_vld && dw_ready;
      if (ev && (!m_vld || xf)) begin
         m_vld = 1; m_sign = sg; m_mag = mg;
      end else if (ev) m_ovf = 1;
      else if (xf) m_vld = 0;
      m_pre  = pre_spike  ? 255 : (tick ? decay(m_pre)  : m_pre);
      m_post = post_spike ? 255 : (tick ? decay(m_post) : m_post);
   endtask

   task automatic step(input bit pr, input bit po, input bit rd, input bit rs);
      pre_spike = pr; post_spike = po; dw_ready = rd; rst = rs;
      @(posedge clk);
      model_edge();
      #1;
      chk("pre_trace", pre_trace, m_pre);
      chk("post_trace", post_trace, m_post);
      chk("dw_valid", dw_valid, m_vld);
      chk("dw_sign", dw_sign, m_sign);
      chk("dw_mag", dw_mag, m_mag);
      chk("dw_overflow", dw_overflow, m_ovf);
   endtask

   initial begin
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      chk("rst_outputs_zero", {pre_trace, post_trace, dw_valid, dw_sign, dw_mag, dw_overflow}, 0);

      // LTP, then a second LTP into a stalled slot
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      chk("ltp_sign", dw_sign, 1);
      chk("ltp_mag", dw_mag, 127);
      step(0, 1, 0, 0);
      chk("ovf_set", dw_overflow, 1);
      chk("held_mag", dw_mag, 127);
      step(0, 0, 1, 0);
      chk("drain_valid", dw_valid, 0);
      chk("ovf_sticky", dw_overflow, 1);

      // reset mid-event with valid and overflow high
      step(0, 1, 0, 0);
      chk("pre_reset_valid", dw_valid, 1);
      step(0, 0, 0, 1);
      chk("reset_clears", {pre_trace, post_trace, dw_valid, dw_sign, dw_mag, dw_overflow}, 0);

      // first decay tick lands on the 4th edge after reset release
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("no_tick_yet", post_trace, 255);
      step(0, 0, 0, 0);
      chk("first_tick", post_trace, 224);

      // LTD from decayed post trace, then event loaded on the same edge as a transfer
      step(1, 0, 1, 0);
      chk("ltd_sign", dw_sign, 0);
      chk("ltd_pre_trace", pre_trace, 255);
      step(0, 1, 1, 0);
      chk("xfer_reload_valid", dw_valid, 1);
      chk("xfer_reload_sign", dw_sign, 1);

      // simultaneous spikes: no event, both traces reload
      step(0, 0, 1, 0);
      step(1, 1, 1, 0);
      chk("simul_no_event", dw_valid, 0);
      chk("simul_traces", {pre_trace, post_trace}, 16'hFFFF);

      // let traces decay fully to the floor
      for (int i = 0; i < 200; i++) step(0, 0, 1, 0);
      chk("floor_zero", {pre_trace, post_trace}, 0);

      for (int i = 0; i < 3000; i++)
         step($urandom_range(7) == 0, $urandom_range(7) == 0,
              $urandom_range(3) != 0, $urandom_range(299) == 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
